// File: rtl/cpu7_csr_excp_pkg.sv
// Shared CSR addresses, field bit ranges and exception codes for the cpu7 CSR unit.
// The optional SAVE0..SAVE3 scratch registers are enabled by CPU7_CSR_SAVE_EN.
`ifndef LSOC1K_CSR_BIT
`define LSOC1K_CSR_BIT 14
`endif

`ifndef CPU7_CSR_FIELDS
`define CPU7_CSR_FIELDS
`define CSR_CRMD_PLV       1:0
`define CSR_CRMD_IE        2
`define CSR_PRMD_PPLV      1:0
`define CSR_PRMD_PIE       2
`define CSR_ECFG_LIE       12:0
`define CSR_ESTAT_IS       12:0
`define CSR_ESTAT_ECODE    21:16
`define CSR_ESTAT_ESUBCODE 30:22
`define CSR_TCFG_EN        0
`define CSR_TCFG_PERIODIC  1
`define CSR_TICLR_CLR      0
`endif

package cpu7_csr_excp_pkg;

  localparam logic [`LSOC1K_CSR_BIT-1:0] CSR_CRMD   = 'h0;
  localparam logic [`LSOC1K_CSR_BIT-1:0] CSR_PRMD   = 'h1;
  localparam logic [`LSOC1K_CSR_BIT-1:0] CSR_ECFG   = 'h4;
  localparam logic [`LSOC1K_CSR_BIT-1:0] CSR_ESTAT  = 'h5;
  localparam logic [`LSOC1K_CSR_BIT-1:0] CSR_ERA    = 'h6;
  localparam logic [`LSOC1K_CSR_BIT-1:0] CSR_BADV   = 'h7;
  localparam logic [`LSOC1K_CSR_BIT-1:0] CSR_EENTRY = 'hC;
  localparam logic [`LSOC1K_CSR_BIT-1:0] CSR_SAVE0  = 'h30;
  localparam logic [`LSOC1K_CSR_BIT-1:0] CSR_SAVE1  = 'h31;
  localparam logic [`LSOC1K_CSR_BIT-1:0] CSR_SAVE2  = 'h32;
  localparam logic [`LSOC1K_CSR_BIT-1:0] CSR_SAVE3  = 'h33;
  localparam logic [`LSOC1K_CSR_BIT-1:0] CSR_TID    = 'h40;
  localparam logic [`LSOC1K_CSR_BIT-1:0] CSR_TCFG   = 'h41;
  localparam logic [`LSOC1K_CSR_BIT-1:0] CSR_TVAL   = 'h42;
  localparam logic [`LSOC1K_CSR_BIT-1:0] CSR_TICLR  = 'h44;

  // Bit 10 of LIE has no interrupt source behind it and stays 0.
  localparam logic [12:0] ECFG_LIE_MASK = 13'h1BFF;

  typedef enum logic [5:0] {
    ECODE_INT = 6'h00,
    ECODE_ALE = 6'h09,
    ECODE_SYS = 6'h0B,
    ECODE_BRK = 6'h0C,
    ECODE_INE = 6'h0D
  } ecode_e;

endpackage

// File: rtl/cpu7_csr_excp_timer.sv
// Countdown timer: TCFG register, TVAL counter and the TI pending bit with
// set-over-clear priority when an expiry and a TICLR write coincide.
module cpu7_csr_excp_timer
  import cpu7_csr_excp_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tcfg_wen,
  input  logic [TIMER_W-1:0] tcfg_wdata,
  input  logic               ti_clr,
  output logic [TIMER_W-1:0] tcfg,
  output logic [TIMER_W-1:0] tval,
  output logic               ti
);

  logic [TIMER_W-1:0] tcfg_reg;
  logic [TIMER_W-1:0] tval_reg;
  logic               ti_reg;
  logic               timer_en;
  logic               expire;

  assign timer_en = tcfg_reg[`CSR_TCFG_EN];
  assign expire   = timer_en && (tval_reg == TIMER_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg_reg <= '0;
      tval_reg <= '0;
      ti_reg   <= 1'b0;
    end else begin
      if (tcfg_wen) begin
        tcfg_reg <= tcfg_wdata;
        tval_reg <= {tcfg_wdata[TIMER_W-1:2], 2'b00};
      end else if (expire) begin
        tval_reg <= tcfg_reg[`CSR_TCFG_PERIODIC] ? {tcfg_reg[TIMER_W-1:2], 2'b00} : '0;
      end else if (timer_en && (tval_reg != '0)) begin
        tval_reg <= tval_reg - TIMER_W'(1);
      end

      if (expire) begin
        ti_reg <= 1'b1;
      end else if (ti_clr) begin
        ti_reg <= 1'b0;
      end
    end
  end

  assign tcfg = tcfg_reg;
  assign tval = tval_reg;
  assign ti   = ti_reg;

endmodule

// File: rtl/cpu7_csr_excp.sv
// cpu7 CSR unit with exception entry/ERTN save-restore, timer and interrupt request.
// Define CPU7_CSR_SAVE_EN to add the SAVE0..SAVE3 scratch registers at 0x30..0x33.
module cpu7_csr_excp
  import cpu7_csr_excp_pkg::*;
#(
  parameter int          GRLEN   = 32,
  parameter int          NUM_HWI = 8,
  parameter int          TIMER_W = 32,
  parameter logic [GRLEN-1:0] TID_RST = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [`LSOC1K_CSR_BIT-1:0] csr_raddr,
  output logic [GRLEN-1:0]           csr_rdata,
  input  logic [`LSOC1K_CSR_BIT-1:0] csr_waddr,
  input  logic [GRLEN-1:0]           csr_wdata,
  input  logic                       csr_wen,
  input  logic                       excp_valid,
  input  logic [5:0]                 excp_ecode,
  input  logic [8:0]                 excp_esubcode,
  input  logic [GRLEN-1:0]           excp_pc,
  input  logic                       excp_badv_valid,
  input  logic [GRLEN-1:0]           excp_badv,
  input  logic                       ertn_valid,
  input  logic [NUM_HWI-1:0]         hw_int,
  output logic [GRLEN-1:0]           csr_eentry,
  output logic [GRLEN-1:0]           csr_era,
  output logic [1:0]                 csr_plv,
  output logic                       int_req
);

  logic [1:0]         crmd_plv_reg;
  logic               crmd_ie_reg;
  logic [1:0]         prmd_pplv_reg;
  logic               prmd_pie_reg;
  logic [12:0]        ecfg_lie_reg;
  logic [1:0]         estat_sw_reg;
  logic [NUM_HWI-1:0] estat_hw_reg;
  logic [5:0]         estat_ecode_reg;
  logic [8:0]         estat_esub_reg;
  logic [GRLEN-1:0]   era_reg;
  logic [GRLEN-1:0]   badv_reg;
  logic [GRLEN-1:7+(-1)] eentry_reg;
  logic [GRLEN-1:0]   tid_reg;

  logic wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv, wr_eentry, wr_tid;
  logic wr_tcfg, wr_ticlr;

  assign wr_crmd   = csr_wen && (csr_waddr == CSR_CRMD);
  assign wr_prmd   = csr_wen && (csr_waddr == CSR_PRMD);
  assign wr_ecfg   = csr_wen && (csr_waddr == CSR_ECFG);
  assign wr_estat  = csr_wen && (csr_waddr == CSR_ESTAT);
  assign wr_era    = csr_wen && (csr_waddr == CSR_ERA);
  assign wr_badv   = csr_wen && (csr_waddr == CSR_BADV);
  assign wr_eentry = csr_wen && (csr_waddr == CSR_EENTRY);
  assign wr_tid    = csr_wen && (csr_waddr == CSR_TID);
  assign wr_tcfg   = csr_wen && (csr_waddr == CSR_TCFG);
  assign wr_ticlr  = csr_wen && (csr_waddr == CSR_TICLR);

  // Exception beats ERTN beats a CSR write, but only on registers the event touches.
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_plv_reg    <= '0;
      crmd_ie_reg     <= 1'b0;
      prmd_pplv_reg   <= '0;
      prmd_pie_reg    <= 1'b0;
      ecfg_lie_reg    <= '0;
      estat_sw_reg    <= '0;
      estat_hw_reg    <= '0;
      estat_ecode_reg <= '0;
      estat_esub_reg  <= '0;
      era_reg         <= '0;
      badv_reg        <= '0;
      eentry_reg      <= '0;
      tid_reg         <= TID_RST;
    end else begin
      estat_hw_reg <= hw_int;

      if (excp_valid) begin
        crmd_plv_reg <= 2'b00;
        crmd_ie_reg  <= 1'b0;
      end else if (ertn_valid) begin
        crmd_plv_reg <= prmd_pplv_reg;
        crmd_ie_reg  <= prmd_pie_reg;
      end else if (wr_crmd) begin
        crmd_plv_reg <= csr_wdata[`CSR_CRMD_PLV];
        crmd_ie_reg  <= csr_wdata[`CSR_CRMD_IE];
      end

      if (excp_valid) begin
        prmd_pplv_reg <= crmd_plv_reg;
        prmd_pie_reg  <= crmd_ie_reg;
      end else if (wr_prmd) begin
        prmd_pplv_reg <= csr_wdata[`CSR_PRMD_PPLV];
        prmd_pie_reg  <= csr_wdata[`CSR_PRMD_PIE];
      end

      if (excp_valid) begin
        estat_ecode_reg <= excp_ecode;
        estat_esub_reg  <= excp_esubcode;
      end else if (wr_estat) begin
        estat_sw_reg <= csr_wdata[1:0];
      end

      if (excp_valid) begin
        era_reg <= excp_pc;
      end else if (wr_era) begin
        era_reg <= csr_wdata;
      end

      if (excp_valid && excp_badv_valid) begin
        badv_reg <= excp_badv;
      end else if (wr_badv) begin
        badv_reg <= csr_wdata;
      end

      if (wr_ecfg) begin
        ecfg_lie_reg <= csr_wdata[`CSR_ECFG_LIE] & ECFG_LIE_MASK;
      end
      if (wr_eentry) begin
        eentry_reg <= csr_wdata[GRLEN-1:6];
      end
      if (wr_tid) begin
        tid_reg <= csr_wdata;
      end
    end
  end

  logic [TIMER_W-1:0] tcfg;
  logic [TIMER_W-1:0] tval;
  logic               ti;

  cpu7_csr_excp_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .tcfg_wen   (wr_tcfg),
    .tcfg_wdata (csr_wdata[TIMER_W-1:0]),
    .ti_clr     (wr_ticlr && csr_wdata[`CSR_TICLR_CLR]),
    .tcfg       (tcfg),
    .tval       (tval),
    .ti         (ti)
  );

  // Hardware lines beyond NUM_HWI are tied off so they always read 0.
  logic [7:0] hw_pad;
  for (genvar gi = 0; gi < 8; gi++) begin : g_hwi
    if (gi < NUM_HWI) begin : g_on
      assign hw_pad[gi] = estat_hw_reg[gi];
    end else begin : g_off
      assign hw_pad[gi] = 1'b0;
    end
  end

  logic [12:0] estat_is;
  assign estat_is = {1'b0, ti, 1'b0, hw_pad, estat_sw_reg};

  logic [GRLEN-1:0] tcfg_ext;
  logic [GRLEN-1:0] tval_ext;
  always_comb begin
    tcfg_ext = '0;
    tval_ext = '0;
    tcfg_ext[TIMER_W-1:0] = tcfg;
    tval_ext[TIMER_W-1:0] = tval;
  end

`ifdef CPU7_CSR_SAVE_EN
  logic [3:0][GRLEN-1:0] save_rd;
  for (genvar gi = 0; gi < 4; gi++) begin : g_save
    logic [GRLEN-1:0] save_reg;
    always_ff @(posedge clk) begin
      if (reset) begin
        save_reg <= '0;
      end else if (csr_wen && (csr_waddr == (CSR_SAVE0 | `LSOC1K_CSR_BIT'(gi)))) begin
        save_reg <= csr_wdata;
      end
    end
    assign save_rd[gi] = save_reg;
  end
`endif

  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      CSR_CRMD:   csr_rdata[2:0]  = {crmd_ie_reg, crmd_plv_reg};
      CSR_PRMD:   csr_rdata[2:0]  = {prmd_pie_reg, prmd_pplv_reg};
      CSR_ECFG:   csr_rdata[12:0] = ecfg_lie_reg;
      CSR_ESTAT:  csr_rdata[30:0] = {estat_esub_reg, estat_ecode_reg, 3'b000, estat_is};
      CSR_ERA:    csr_rdata       = era_reg;
      CSR_BADV:   csr_rdata       = badv_reg;
      CSR_EENTRY: csr_rdata       = {eentry_reg, 6'b000000};
      CSR_TID:    csr_rdata       = tid_reg;
      CSR_TCFG:   csr_rdata       = tcfg_ext;
      CSR_TVAL:   csr_rdata       = tval_ext;
`ifdef CPU7_CSR_SAVE_EN
      CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                  csr_rdata       = save_rd[csr_raddr[1:0]];
`endif
      default:    csr_rdata       = '0;
    endcase
  end

  assign csr_eentry = {eentry_reg, 6'b000000};
  assign csr_era    = era_reg;
  assign csr_plv    = crmd_plv_reg;
  assign int_req    = crmd_ie_reg && |(estat_is & ecfg_lie_reg);

endmodule

// File: tb/tb_cpu7_csr_excp.sv
// Directed self-checking bench for cpu7_csr_excp: exception/ERTN, EENTRY,
// write masks, one-shot and periodic timer, interrupt request, reset mid-count.
module tb_cpu7_csr_excp;
  import cpu7_csr_excp_pkg::*;

  localparam logic [31:0] TID_INIT = 32'h0000_00A5;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic [`LSOC1K_CSR_BIT-1:0] csr_raddr = '0;
  logic [31:0]                csr_rdata;
  logic [`LSOC1K_CSR_BIT-1:0] csr_waddr = '0;
  logic [31:0]                csr_wdata = '0;
  logic                       csr_wen = 1'b0;
  logic                       excp_valid = 1'b0;
  logic [5:0]                 excp_ecode = '0;
  logic [8:0]                 excp_esubcode = '0;
  logic [31:0]                excp_pc = '0;
  logic                       excp_badv_valid = 1'b0;
  logic [31:0]                excp_badv = '0;
  logic                       ertn_valid = 1'b0;
  logic [7:0]                 hw_int = '0;
  logic [31:0]                csr_eentry;
  logic [31:0]                csr_era;
  logic [1:0]                 csr_plv;
  logic                       int_req;

  int checks = 0;
  int errors = 0;

  cpu7_csr_excp #(
    .GRLEN   (32),
    .NUM_HWI (8),
    .TIMER_W (32),
    .TID_RST (TID_INIT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .csr_raddr       (csr_raddr),
    .csr_rdata       (csr_rdata),
    .csr_waddr       (csr_waddr),
    .csr_wdata       (csr_wdata),
    .csr_wen         (csr_wen),
    .excp_valid      (excp_valid),
    .excp_ecode      (excp_ecode),
    .excp_esubcode   (excp_esubcode),
    .excp_pc         (excp_pc),
    .excp_badv_valid (excp_badv_valid),
    .excp_badv       (excp_badv),
    .ertn_valid      (ertn_valid),
    .hw_int          (hw_int),
    .csr_eentry      (csr_eentry),
    .csr_era         (csr_era),
    .csr_plv         (csr_plv),
    .int_req         (int_req)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [`LSOC1K_CSR_BIT-1:0] a, output logic [31:0] d);
    csr_raddr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic chk_csr(input string tag, input logic [`LSOC1K_CSR_BIT-1:0] a,
                         input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [`LSOC1K_CSR_BIT-1:0] a, input logic [31:0] d);
    csr_waddr = a;
    csr_wdata = d;
    csr_wen   = 1'b1;
    tick();
    csr_wen   = 1'b0;
  endtask

  initial begin
    logic [31:0] d;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk_csr("rst_crmd", CSR_CRMD, 32'h0);
    chk_csr("rst_estat", CSR_ESTAT, 32'h0);
    chk_csr("rst_tid", CSR_TID, TID_INIT);
    chk_csr("rst_tval", CSR_TVAL, 32'h0);
    check("rst_int_req", {31'b0, int_req}, 32'h0);
    check("rst_eentry_out", csr_eentry, 32'h0);

    // Exception entry and ERTN
    wr(CSR_CRMD, 32'h7);
    chk_csr("crmd_wr", CSR_CRMD, 32'h7);
    check("plv_out", {30'b0, csr_plv}, 32'h3);
    excp_valid      = 1'b1;
    excp_pc         = 32'h1C00_0100;
    excp_ecode      = ECODE_SYS;
    excp_esubcode   = 9'h001;
    excp_badv_valid = 1'b1;
    excp_badv       = 32'hDEAD_BEEF;
    tick();
    excp_valid      = 1'b0;
    excp_badv_valid = 1'b0;
    chk_csr("excp_crmd", CSR_CRMD, 32'h0);
    chk_csr("excp_prmd", CSR_PRMD, 32'h7);
    chk_csr("excp_era", CSR_ERA, 32'h1C00_0100);
    chk_csr("excp_estat", CSR_ESTAT, 32'h004B_0000);
    chk_csr("excp_badv", CSR_BADV, 32'hDEAD_BEEF);
    check("era_out", csr_era, 32'h1C00_0100);
    ertn_valid = 1'b1;
    tick();
    ertn_valid = 1'b0;
    chk_csr("ertn_crmd", CSR_CRMD, 32'h7);

    // No write bypass: same-cycle read returns the old value
    csr_waddr = CSR_CRMD;
    csr_wdata = 32'h3;
    csr_wen   = 1'b1;
    rd(CSR_CRMD, d);
    check("no_bypass", d, 32'h7);
    tick();
    csr_wen = 1'b0;
    chk_csr("crmd_after_wr", CSR_CRMD, 32'h3);

    // Exception beats a CRMD write; a TID write alongside an exception completes
    excp_valid = 1'b1;
    excp_ecode = ECODE_INE;
    excp_esubcode = 9'h000;
    wr(CSR_CRMD, 32'h3);
    chk_csr("excp_vs_wr_crmd", CSR_CRMD, 32'h0);
    wr(CSR_TID, 32'h0000_1234);
    excp_valid = 1'b0;
    chk_csr("excp_wr_tid", CSR_TID, 32'h0000_1234);
    chk_csr("excp_prmd_plv0", CSR_PRMD, 32'h0);

    // EENTRY low bits, write masks, read-only/zero registers
    wr(CSR_EENTRY, 32'h1C00_8FFF);
    chk_csr("eentry_rd", CSR_EENTRY, 32'h1C00_8FC0);
    check("eentry_out", csr_eentry, 32'h1C00_8FC0);
    wr(CSR_ECFG, 32'hFFFF_FFFF);
    chk_csr("ecfg_mask", CSR_ECFG, 32'h0000_1BFF);
    wr(CSR_ESTAT, 32'hFFFF_FFFF);
    rd(CSR_ESTAT, d);
    check("estat_sw_mask", d & 32'h0000_1FFF, 32'h3);
    wr(CSR_ESTAT, 32'h0);
    wr(CSR_TVAL, 32'h55);
    chk_csr("tval_ro", CSR_TVAL, 32'h0);
    chk_csr("ticlr_rd0", CSR_TICLR, 32'h0);
    wr(CSR_SAVE1, 32'hCAFE_F00D);
`ifdef CPU7_CSR_SAVE_EN
    chk_csr("save1", CSR_SAVE1, 32'hCAFE_F00D);
`else
    chk_csr("save1_off", CSR_SAVE1, 32'h0);
`endif

    // One-shot timer, InitVal 8
    wr(CSR_TCFG, 32'h9);
    chk_csr("tcfg_rd", CSR_TCFG, 32'h9);
    chk_csr("os_tval_8", CSR_TVAL, 32'h8);
    for (int i = 7; i >= 1; i--) begin
      tick();
      chk_csr($sformatf("os_tval_%0d", i), CSR_TVAL, i);
    end
    rd(CSR_ESTAT, d);
    check("os_ti_pre", (d >> 11) & 32'h1, 32'h0);
    tick();
    rd(CSR_ESTAT, d);
    check("os_ti_set", (d >> 11) & 32'h1, 32'h1);
    chk_csr("os_tval_0", CSR_TVAL, 32'h0);
    tick();
    tick();
    chk_csr("os_tval_stay0", CSR_TVAL, 32'h0);
    wr(CSR_TICLR, 32'h1);
    rd(CSR_ESTAT, d);
    check("os_ti_clr", (d >> 11) & 32'h1, 32'h0);

    // Periodic timer, reload and set-over-clear
    wr(CSR_TCFG, 32'hB);
    for (int i = 0; i < 7; i++) tick();
    chk_csr("per_tval_1", CSR_TVAL, 32'h1);
    tick();
    rd(CSR_ESTAT, d);
    check("per_ti_set", (d >> 11) & 32'h1, 32'h1);
    chk_csr("per_reload", CSR_TVAL, 32'h8);
    wr(CSR_TICLR, 32'h1);
    rd(CSR_ESTAT, d);
    check("per_ti_clr", (d >> 11) & 32'h1, 32'h0);
    chk_csr("per_tval_7", CSR_TVAL, 32'h7);
    for (int i = 0; i < 6; i++) tick();
    chk_csr("per_tval_1b", CSR_TVAL, 32'h1);
    wr(CSR_TICLR, 32'h1);
    rd(CSR_ESTAT, d);
    check("per_set_wins", (d >> 11) & 32'h1, 32'h1);
    chk_csr("per_reload2", CSR_TVAL, 32'h8);
    wr(CSR_TCFG, 32'h0);
    chk_csr("tcfg_off_tval", CSR_TVAL, 32'h0);

    // Interrupt request from hw_int[0] (IS bit 2)
    wr(CSR_ECFG, 32'h4);
    wr(CSR_CRMD, 32'h4);
    hw_int = 8'h01;
    #1;
    check("irq_latency", {31'b0, int_req}, 32'h0);
    tick();
    check("irq_set", {31'b0, int_req}, 32'h1);
    rd(CSR_ESTAT, d);
    check("estat_hwi0", d & 32'h0000_0004, 32'h4);
    wr(CSR_CRMD, 32'h0);
    check("irq_ie_off", {31'b0, int_req}, 32'h0);

    // Reset mid-count
    wr(CSR_CRMD, 32'h4);
    check("irq_before_rst", {31'b0, int_req}, 32'h1);
    wr(CSR_TCFG, 32'h41);
    tick();
    tick();
    tick();
    chk_csr("mid_tval", CSR_TVAL, 32'h3D);
    reset = 1'b1;
    tick();
    chk_csr("rst_mid_tval", CSR_TVAL, 32'h0);
    chk_csr("rst_mid_tcfg", CSR_TCFG, 32'h0);
    chk_csr("rst_mid_estat", CSR_ESTAT, 32'h0);
    chk_csr("rst_mid_crmd", CSR_CRMD, 32'h0);
    chk_csr("rst_mid_tid", CSR_TID, TID_INIT);
    check("rst_mid_irq", {31'b0, int_req}, 32'h0);
    check("rst_mid_era", csr_era, 32'h0);
    reset = 1'b0;
    tick();
    chk_csr("post_rst_hwi", CSR_ESTAT, 32'h0000_0004);
    tick();
    chk_csr("post_rst_tval", CSR_TVAL, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
